// File: rtl/nibble_serial_adder_if.sv
// Operand/result bundle for the nibble-serial adder: request side (a, b, cin)
// and response side (sum, cout), each with its own valid/ready pair.
interface nibble_serial_adder_if #(
    parameter int W = 16
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         busy;

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, busy
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, busy
    );
endinterface

// File: rtl/nibble_serial_adder.sv
// Adds W-bit operands one nibble per clock through a single 4-bit slice; result valid
// N=W/4 edges after accept, held in DONE until out_ready, no new operands taken meanwhile.
module nibble_serial_adder #(
    parameter int W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    nibble_serial_adder_if.slave bus
);
    localparam int N  = W / 4;
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state_q, state_d;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    logic [W-1:0]  sum_q, sum_d;
    logic          carry_q, carry_d;
    logic          cout_q, cout_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [4:0]    slice;
    logic          accept;

    assign slice  = {1'b0, a_q[3:0]} + {1'b0, b_q[3:0]} + {4'b0000, carry_q};
    assign accept = bus.in_valid && bus.in_ready;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    carry_d = bus.cin;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                // Each slice result enters at the top, so after N steps nibble 0 sits at the bottom.
                sum_d   = W'({slice[3:0], sum_q} >> 4);
                a_d     = a_q >> 4;
                b_d     = b_q >> 4;
                carry_d = slice[4];
                idx_d   = idx_q + IW'(1);
                if (idx_q == IW'(N - 1)) begin
                    cout_d  = slice[4];
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            idx_q   <= idx_d;
        end
    end

    // in_ready drops combinationally with rst so a request alongside reset is never taken.
    assign bus.in_ready  = (state_q == IDLE) && !rst;
    assign bus.out_valid = (state_q == DONE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
endmodule

// File: tb/tb_nibble_serial_adder.sv
// Scoreboard bench for nibble_serial_adder at W=16, W=4 and W=32.
module tb_nibble_serial_adder;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst16;
    logic rst_x;
    int   n_vec = 0;
    int   n_err = 0;

    nibble_serial_adder_if #(.W(16)) bus16 ();
    nibble_serial_adder_if #(.W(4))  bus4  ();
    nibble_serial_adder_if #(.W(32)) bus32 ();

    nibble_serial_adder #(.W(16)) u_dut16 (.clk(clk), .rst(rst16), .bus(bus16));
    nibble_serial_adder #(.W(4))  u_dut4  (.clk(clk), .rst(rst_x), .bus(bus4));
    nibble_serial_adder #(.W(32)) u_dut32 (.clk(clk), .rst(rst_x), .bus(bus32));

    logic [16:0] sb16[$];
    logic [4:0]  sb4[$];
    logic [32:0] sb32[$];
    logic [16:0] e16;
    logic [4:0]  e4;
    logic [32:0] e32;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitors: one pop per completed output handshake.
    always @(negedge clk) begin
        if (!rst16 && bus16.out_valid && bus16.out_ready) begin
            if (sb16.size() == 0) check("w16_spurious_out", bus16.out_valid, 0);
            else begin
                e16 = sb16.pop_front();
                check("w16_result", {bus16.cout, bus16.sum}, e16);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_x && bus4.out_valid && bus4.out_ready) begin
            if (sb4.size() == 0) check("w4_spurious_out", bus4.out_valid, 0);
            else begin
                e4 = sb4.pop_front();
                check("w4_result", {bus4.cout, bus4.sum}, e4);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_x && bus32.out_valid && bus32.out_ready) begin
            if (sb32.size() == 0) check("w32_spurious_out", bus32.out_valid, 0);
            else begin
                e32 = sb32.pop_front();
                check("w32_result", {bus32.cout, bus32.sum}, e32);
            end
        end
    end

    task automatic wait_ready16();
        int k = 0;
        @(negedge clk);
        while (!bus16.in_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (!bus16.in_ready) check("w16_accept_timeout", bus16.in_ready, 1);
    endtask

    // Called just after a posedge; returns just after the accepting posedge.
    task automatic send16(input logic [15:0] av, input logic [15:0] bv, input logic c,
                          input logic [16:0] ex, input bit push);
        bus16.in_valid = 1'b1;
        bus16.a = av;
        bus16.b = bv;
        bus16.cin = c;
        wait_ready16();
        @(posedge clk);
        if (push) sb16.push_back(ex);
        #1;
        bus16.in_valid = 1'b0;
        bus16.a = ~av;
        bus16.b = ~bv;
        bus16.cin = ~c;
    endtask

    // Returns at the negedge of the first DONE cycle.
    task automatic wait_valid16();
        int lat = 0;
        @(negedge clk);
        while (!bus16.out_valid && lat < 40) begin
            check("w16_in_ready_while_busy", bus16.in_ready, 0);
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        check("w16_latency", lat, 4);
    endtask

    task automatic handshake16();
        @(posedge clk);
        #1 bus16.out_ready = 1'b1;
        @(negedge clk);
        check("w16_in_ready_at_handshake", bus16.in_ready, 0);
        @(posedge clk);
        #1 bus16.out_ready = 1'b0;
        @(negedge clk);
        check("w16_in_ready_after_hs", bus16.in_ready, 1);
        check("w16_out_valid_after_hs", bus16.out_valid, 0);
        @(posedge clk);
        #1;
    endtask

    task automatic stream16(input int n, input bit rnd);
        logic [15:0] av, bv;
        logic        c;
        logic [16:0] ex;
        logic [15:0] ta[5] = '{16'h0000, 16'h8000, 16'h0FFF, 16'h7FFF, 16'hABCD};
        logic [15:0] tb[5] = '{16'h0000, 16'h8000, 16'h0001, 16'h7FFF, 16'h1111};
        logic        tc[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [16:0] te[5] = '{17'h00000, 17'h10000, 17'h01000, 17'h0FFFF, 17'h0BCDF};
        time last = 0;
        int k;
        bus16.out_ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            if (rnd) begin
                av = 16'($urandom);
                bv = 16'($urandom);
                c  = 1'($urandom_range(0, 1));
                ex = {1'b0, av} + {1'b0, bv} + {16'h0000, c};
            end else begin
                av = ta[i]; bv = tb[i]; c = tc[i]; ex = te[i];
            end
            bus16.in_valid = 1'b1;
            bus16.a = av;
            bus16.b = bv;
            bus16.cin = c;
            wait_ready16();
            @(posedge clk);
            sb16.push_back(ex);
            if (i > 0) check("w16_stream_interval", 64'(($time - last) / 10), 6);
            last = $time;
            #1;
        end
        bus16.in_valid = 1'b0;
        k = 0;
        while (sb16.size() != 0 && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("w16_drain", sb16.size(), 0);
        @(posedge clk);
        #1 bus16.out_ready = 1'b0;
    endtask

    task automatic run16();
        // 1: all-ones plus one ripples a carry through every nibble
        send16(16'hFFFF, 16'h0001, 1'b0, 17'h10000, 1);
        wait_valid16();
        check("t1_busy", bus16.busy, 1);
        handshake16();
        // 2
        send16(16'h1234, 16'h4321, 1'b1, 17'h05556, 1);
        wait_valid16();
        handshake16();
        // 3: backpressure with a stray in_valid pulse
        send16(16'h00FF, 16'h0F01, 1'b0, 17'h01000, 1);
        wait_valid16();
        for (int k = 0; k < 5; k++) begin
            check("t3_hold_valid", bus16.out_valid, 1);
            check("t3_hold_result", {bus16.cout, bus16.sum}, 17'h01000);
            check("t3_in_ready", bus16.in_ready, 0);
            @(posedge clk);
            #1;
            bus16.in_valid  = (k == 1);
            bus16.a         = 16'h5555;
            bus16.out_ready = (k == 4);
            @(negedge clk);
        end
        @(posedge clk);
        #1 bus16.out_ready = 1'b0;
        @(negedge clk);
        check("t3_idle_ready", bus16.in_ready, 1);
        check("t3_idle_busy", bus16.busy, 0);
        @(posedge clk);
        #1;
        // 4: reset two cycles after accept, with in_valid also high during reset
        send16(16'h1111, 16'h2222, 1'b0, 17'h0, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst16 = 1'b1;
        bus16.in_valid = 1'b1;
        bus16.a = 16'hAAAA;
        @(negedge clk);
        check("t4_in_ready_in_rst", bus16.in_ready, 0);
        @(posedge clk);
        #1;
        rst16 = 1'b0;
        bus16.in_valid = 1'b0;
        @(negedge clk);
        check("t4_ready_after_rst", bus16.in_ready, 1);
        check("t4_busy_after_rst", bus16.busy, 0);
        for (int k = 0; k < 6; k++) begin
            check("t4_no_valid", bus16.out_valid, 0);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        send16(16'h0001, 16'h0001, 1'b0, 17'h00002, 1);
        wait_valid16();
        handshake16();
        // 5 and 6 (W=16 random)
        stream16(5, 0);
        stream16(1000, 1);
    endtask

    task automatic run4();
        logic [3:0] ta[4] = '{4'hF, 4'h0, 4'h7, 4'h9};
        logic [3:0] tb[4] = '{4'h1, 4'h0, 4'h8, 4'h9};
        logic       tc[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic [4:0] te[4] = '{5'h11, 5'h00, 5'h10, 5'h12};
        int k;
        for (int i = 0; i < 4; i++) begin
            bus4.in_valid = 1'b1;
            bus4.a = ta[i];
            bus4.b = tb[i];
            bus4.cin = tc[i];
            k = 0;
            @(negedge clk);
            while (!bus4.in_ready && k < 50) begin
                @(negedge clk);
                k++;
            end
            if (!bus4.in_ready) check("w4_accept_timeout", bus4.in_ready, 1);
            @(posedge clk);
            sb4.push_back(te[i]);
            #1 bus4.in_valid = 1'b0;
            k = 0;
            @(negedge clk);
            while (!bus4.out_valid && k < 20) begin
                @(posedge clk);
                k++;
                @(negedge clk);
            end
            check("w4_latency", k, 1);
            @(posedge clk);
            #1 bus4.out_ready = 1'b1;
            @(posedge clk);
            #1 bus4.out_ready = 1'b0;
        end
        check("w4_drain", sb4.size(), 0);
    endtask

    task automatic run32();
        logic [31:0] av, bv;
        logic        c;
        int k;
        bus32.out_ready = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            av = $urandom;
            bv = $urandom;
            c  = 1'($urandom_range(0, 1));
            bus32.in_valid = 1'b1;
            bus32.a = av;
            bus32.b = bv;
            bus32.cin = c;
            k = 0;
            @(negedge clk);
            while (!bus32.in_ready && k < 50) begin
                @(negedge clk);
                k++;
            end
            if (!bus32.in_ready) check("w32_accept_timeout", bus32.in_ready, 1);
            @(posedge clk);
            sb32.push_back({1'b0, av} + {1'b0, bv} + {32'h0, c});
            #1;
        end
        bus32.in_valid = 1'b0;
        k = 0;
        while (sb32.size() != 0 && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("w32_drain", sb32.size(), 0);
    endtask

    initial begin
        rst16 = 1'b1;
        rst_x = 1'b1;
        bus16.in_valid = 1'b0; bus16.a = '0; bus16.b = '0; bus16.cin = 1'b0; bus16.out_ready = 1'b0;
        bus4.in_valid  = 1'b0; bus4.a  = '0; bus4.b  = '0; bus4.cin  = 1'b0; bus4.out_ready  = 1'b0;
        bus32.in_valid = 1'b0; bus32.a = '0; bus32.b = '0; bus32.cin = 1'b0; bus32.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", bus16.in_ready, 0);
        check("rst_out_valid", bus16.out_valid, 0);
        check("rst_busy", bus16.busy, 0);
        check("rst_sum_cout", {bus16.cout, bus16.sum}, 17'h0);
        check("rst_w32_in_ready", bus32.in_ready, 0);
        @(posedge clk);
        #1;
        rst16 = 1'b0;
        rst_x = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", bus16.in_ready, 1);
        check("post_rst_w4_in_ready", bus4.in_ready, 1);
        @(posedge clk);
        #1;
        fork
            run16();
            run4();
            run32();
        join
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end
endmodule
